// File: rtl/ex37_full_adder_pkg.sv
// Shared constants for the ex37 ripple-carry full adder slice.
package ex37_full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/ex37_full_adder_fa_bit.sv
// One-bit full adder cell; the ripple chain in ex37_full_adder is built from these.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ex37_full_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum/cout and registered copies.
module ex37_full_adder
  import ex37_full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // Carry ripples LSB to MSB; cout is the carry leaving the top cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .co  (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_ex37_full_adder.sv
// Self-checking bench for ex37_full_adder at WIDTH=1 and WIDTH=4.
module tb_ex37_full_adder;

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       sum1, cout1, sum_q1, cout_q1;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4, sum_q4;
  logic       cout4, cout_q4;

  int n_checks;
  int n_fail;

  ex37_full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1)
  );

  ex37_full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4)
  );

  task automatic pulse_clk();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic test_reset();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4 = 4'hA; b4 = 4'h7; cin4 = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_w1: got sum_q=%b cout_q=%b, want 0 0", sum_q1, cout_q1);
    end
    n_checks++;
    if ({cout_q4, sum_q4} !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_w4: got cout_q=%b sum_q=%h, want 0 0", cout_q4, sum_q4);
    end
    pulse_clk();
    n_checks++;
    if ({cout_q4, sum_q4} !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_held_edge: got cout_q=%b sum_q=%h, want 0 0", cout_q4, sum_q4);
    end
    // Combinational path keeps working while reset is held: 10+7+1 = 18.
    n_checks++;
    if ({cout4, sum4} !== 5'd18) begin
      n_fail++;
      $display("FAIL comb_in_reset: got %0d, want 18", {cout4, sum4});
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_vectors();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #1;
    n_checks++;
    if ({sum1, cout1} !== 2'b11) begin
      n_fail++;
      $display("FAIL fa_111: got sum=%b cout=%b, want 1 1", sum1, cout1);
    end
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    #1;
    n_checks++;
    if ({sum1, cout1} !== 2'b10) begin
      n_fail++;
      $display("FAIL fa_100: got sum=%b cout=%b, want 1 0", sum1, cout1);
    end
  endtask

  task automatic test_exhaustive_1bit();
    for (int v = 0; v < 8; v++) begin
      int total;
      a1   = v[2];
      b1   = v[1];
      cin1 = v[0];
      total = int'(v[2]) + int'(v[1]) + int'(v[0]);
      #1;
      n_checks++;
      if ({cout1, sum1} !== 2'(total)) begin
        n_fail++;
        $display("FAIL truth_table a=%b b=%b cin=%b: got cout=%b sum=%b, want %0d",
                 a1, b1, cin1, cout1, sum1, total);
      end
    end
  endtask

  task automatic test_registered_path();
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    pulse_clk();
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reg_100: got sum_q=%b cout_q=%b, want 1 0", sum_q1, cout_q1);
    end
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #1;
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reg_hold_before_edge: got sum_q=%b cout_q=%b, want 1 0", sum_q1, cout_q1);
    end
    pulse_clk();
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b01) begin
      n_fail++;
      $display("FAIL reg_110: got sum_q=%b cout_q=%b, want 0 1", sum_q1, cout_q1);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got sum_q=%b cout_q=%b, want 0 0", sum_q1, cout_q1);
    end
    n_checks++;
    if ({sum1, cout1} !== 2'b01) begin
      n_fail++;
      $display("FAIL comb_during_reset: got sum=%b cout=%b, want 0 1", sum1, cout1);
    end
    rst = 1'b0;
    #1;
    pulse_clk();
    n_checks++;
    if ({sum_q1, cout_q1} !== 2'b01) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: got sum_q=%b cout_q=%b, want 0 1", sum_q1, cout_q1);
    end
  endtask

  task automatic test_wide_boundary();
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    n_checks++;
    if ({cout4, sum4} !== 5'h10) begin
      n_fail++;
      $display("FAIL w4_F_0_1: got cout=%b sum=%h, want 1 0", cout4, sum4);
    end
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #1;
    n_checks++;
    if ({cout4, sum4} !== 5'h1F) begin
      n_fail++;
      $display("FAIL w4_wrap: got cout=%b sum=%h, want 1 F", cout4, sum4);
    end
  endtask

  task automatic test_random_sweep();
    for (int i = 0; i < 1000; i++) begin
      int total;
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      total = int'(a4) + int'(b4) + int'(cin4);
      #1;
      n_checks++;
      if ({cout4, sum4} !== 5'(total)) begin
        n_fail++;
        $display("FAIL w4_random a=%h b=%h cin=%b: got %0d, want %0d",
                 a4, b4, cin4, {cout4, sum4}, total);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 50; i++) begin
      int total;
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      total = int'(a4) + int'(b4) + int'(cin4);
      pulse_clk();
      n_checks++;
      if ({cout_q4, sum_q4} !== 5'(total)) begin
        n_fail++;
        $display("FAIL w4_registered a=%h b=%h cin=%b: got %0d, want %0d",
                 a4, b4, cin4, {cout_q4, sum_q4}, total);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single_vectors();
    test_exhaustive_1bit();
    test_registered_path();
    test_wide_boundary();
    test_random_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
